wbs_mem_slave: RTL and testbench

- Wishbone slave memory for the responding end of the core's Wishbone master port: on-chip RAM, 64-bit data path, byte-lane writes.
- Programmable wait states and an address-window decode; out-of-window accesses end with an error instead of an acknowledge.
- Instantiated beside the S1 core top level as boot/scratch memory and as the bench target for the master bridge.

---
 rtl/wbs_mem_slave_if.sv | 31 +++
 rtl/wbs_mem_slave.sv | 166 ++++++++++++++++
 tb/tb_wbs_mem_slave.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wbs_mem_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : wbs_mem_slave_if
// Description : Wishbone bus bundle between a master and wbs_mem_slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface wbs_mem_slave_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 64
);
   logic                    wbs_cycle_i;
   logic                    wbs_strobe_i;
   logic                    wbs_we_i;
   logic [ADDR_WIDTH-1:0]   wbs_addr_i;
   logic [DATA_WIDTH-1:0]   wbs_data_i;
   logic [DATA_WIDTH/8-1:0] wbs_sel_i;
   logic                    wbs_ack_o;
   logic                    wbs_err_o;
   logic [DATA_WIDTH-1:0]   wbs_data_o;

   modport master (
      output wbs_cycle_i, wbs_strobe_i, wbs_we_i, wbs_addr_i, wbs_data_i, wbs_sel_i,
      input  wbs_ack_o, wbs_err_o, wbs_data_o
   );

   modport slave (
      input  wbs_cycle_i, wbs_strobe_i, wbs_we_i, wbs_addr_i, wbs_data_i, wbs_sel_i,
      output wbs_ack_o, wbs_err_o, wbs_data_o
   );
endinterface
`default_nettype wire

// File: rtl/wbs_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : wbs_mem_slave
// Description : Wishbone slave RAM with byte-lane writes, programmable wait
//               states and an address window that errors outside its range.
// Revision    : 1.0 - initial release
// ============================================================================
module wbs_mem_slave #(
   parameter int                    DATA_WIDTH  = 64,
   parameter int                    ADDR_WIDTH  = 64,
   parameter int                    DEPTH_LOG2  = 10,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    WAIT_STATES = 1
) (
   input  logic           sys_clock_i,
   input  logic           sys_reset_i,
   wbs_mem_slave_if.slave wbs
);
   localparam int         c_LANES    = DATA_WIDTH / 8;
   localparam int         c_OFF_BITS = $clog2(c_LANES);
   localparam int         c_TOP_LSB  = c_OFF_BITS + DEPTH_LOG2;
   localparam int         c_WORDS    = 1 << DEPTH_LOG2;
   localparam logic [3:0] c_WS_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;

   logic                  we_q;
   logic                  inwin_q;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [c_LANES-1:0]    sel_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic [DATA_WIDTH-1:0] mem_q [c_WORDS];

   logic                  w_req;
   logic                  w_live_inwin;
   logic [DEPTH_LOG2-1:0] w_live_idx;
   logic                  w_in_idle;
   logic                  w_eff_we;
   logic                  w_eff_inwin;
   logic [DEPTH_LOG2-1:0] w_eff_idx;
   logic [DATA_WIDTH-1:0] w_eff_wdata;
   logic [c_LANES-1:0]    w_eff_sel;
   logic                  w_commit;

   assign w_req      = wbs.wbs_cycle_i & wbs.wbs_strobe_i;
   assign w_live_idx = wbs.wbs_addr_i[c_OFF_BITS +: DEPTH_LOG2];

   generate
      if (ADDR_WIDTH > c_TOP_LSB) begin : g_win_cmp
         assign w_live_inwin = (wbs.wbs_addr_i[ADDR_WIDTH-1:c_TOP_LSB] ==
                                BASE_ADDR[ADDR_WIDTH-1:c_TOP_LSB]);
      end else begin : g_win_all
         assign w_live_inwin = 1'b1;
      end

      if (c_OFF_BITS > 0) begin : g_off_unused
         logic w_unused;
         assign w_unused = ^wbs.wbs_addr_i[c_OFF_BITS-1:0];
      end
   endgenerate

   // With zero wait states RESP is entered straight from IDLE, so the live
   // bus values are used for that commit instead of the not-yet-latched copy.
   assign w_in_idle   = (state_q == S_IDLE);
   assign w_eff_we    = w_in_idle ? wbs.wbs_we_i   : we_q;
   assign w_eff_inwin = w_in_idle ? w_live_inwin   : inwin_q;
   assign w_eff_idx   = w_in_idle ? w_live_idx     : idx_q;
   assign w_eff_wdata = w_in_idle ? wbs.wbs_data_i : wdata_q;
   assign w_eff_sel   = w_in_idle ? wbs.wbs_sel_i  : sel_q;

   // RESP always falls back to IDLE, so state_d==RESP marks the entry edge only.
   assign w_commit    = (state_d == S_RESP) & ~sys_reset_i;

   always_ff @(posedge sys_clock_i) begin
      if (sys_reset_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (w_req) begin
               if (WAIT_STATES > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = c_WS_LOAD;
               end else begin
                  state_d = S_RESP;
               end
            end
         end
         S_WAIT: begin
            if (!w_req) begin
               state_d = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_comb begin
      wbs.wbs_ack_o  = 1'b0;
      wbs.wbs_err_o  = 1'b0;
      wbs.wbs_data_o = '0;
      if ((state_q == S_RESP) && !sys_reset_i) begin
         wbs.wbs_ack_o  = inwin_q;
         wbs.wbs_err_o  = ~inwin_q;
         wbs.wbs_data_o = rdata_q;
      end
   end

   always_ff @(posedge sys_clock_i) begin
      if (w_in_idle && w_req) begin
         we_q    <= wbs.wbs_we_i;
         inwin_q <= w_live_inwin;
         idx_q   <= w_live_idx;
         wdata_q <= wbs.wbs_data_i;
         sel_q   <= wbs.wbs_sel_i;
      end
   end

   always_ff @(posedge sys_clock_i) begin
      if (w_commit && w_eff_inwin && w_eff_we) begin
         for (int i = 0; i < c_LANES; i++) begin
            if (w_eff_sel[i]) begin
               mem_q[w_eff_idx][8*i +: 8] <= w_eff_wdata[8*i +: 8];
            end
         end
      end
   end

   // Read data lives only for the RESP cycle; every other cycle it is zero.
   always_ff @(posedge sys_clock_i) begin
      if (sys_reset_i) begin
         rdata_q <= '0;
      end else if (w_commit && w_eff_inwin && !w_eff_we) begin
         rdata_q <= mem_q[w_eff_idx];
      end else begin
         rdata_q <= '0;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_wbs_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_wbs_mem_slave
// Description : Self-checking bench for wbs_mem_slave over four configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wbs_mem_slave;
   logic        clk;
   logic        rst;
   logic [1:0]  dut_sel;
   logic        cyc, stb, we;
   logic [63:0] addr, wdata;
   logic [7:0]  sel;

   logic        ack_a   [4];
   logic        err_a   [4];
   logic [63:0] rdata_a [4];
   logic        ack_m, err_m;
   logic [63:0] rdata_m;

   int n_checks;
   int n_pass;

   logic [63:0] mm [int];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      wbs_mem_slave_if #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) bus ();
      assign bus.wbs_cycle_i  = cyc & (dut_sel == 2'(g));
      assign bus.wbs_strobe_i = stb & (dut_sel == 2'(g));
      assign bus.wbs_we_i     = we;
      assign bus.wbs_addr_i   = addr;
      assign bus.wbs_data_i   = wdata;
      assign bus.wbs_sel_i    = sel;
      assign ack_a[g]         = bus.wbs_ack_o;
      assign err_a[g]         = bus.wbs_err_o;
      assign rdata_a[g]       = bus.wbs_data_o;
      wbs_mem_slave #(
         .DATA_WIDTH (64),
         .ADDR_WIDTH (64),
         .DEPTH_LOG2 (10),
         .BASE_ADDR  ((g == 1) ? 64'h1000_0000 : 64'h0),
         .WAIT_STATES((g == 2) ? 0 : ((g == 3) ? 3 : 1))
      ) u_dut (
         .sys_clock_i(clk),
         .sys_reset_i(rst),
         .wbs        (bus)
      );
   end

   assign ack_m   = ack_a[dut_sel];
   assign err_m   = err_a[dut_sel];
   assign rdata_m = rdata_a[dut_sel];

   function automatic logic [63:0] base_of(int k);
      return (k == 1) ? 64'h1000_0000 : 64'h0;
   endfunction

   function automatic int ws_of(int k);
      return (k == 2) ? 0 : ((k == 3) ? 3 : 1);
   endfunction

   // Window is 1024 words of 8 bytes starting at the configuration's base.
   function automatic logic in_window(int k, logic [63:0] a);
      return (a >= base_of(k)) && (a < base_of(k) + 64'd8192);
   endfunction

   function automatic int key_of(int k, logic [63:0] a);
      return k * 4096 + int'((a - base_of(k)) >> 3);
   endfunction

   function automatic void model_apply(int k, logic w, logic [63:0] a, logic [63:0] d, logic [7:0] s);
      logic [63:0] word;
      int          key;
      if (!w || !in_window(k, a)) return;
      key  = key_of(k, a);
      word = mm.exists(key) ? mm[key] : 64'hx;
      for (int b = 0; b < 8; b++) begin
         if (s[b]) word[8*b +: 8] = d[8*b +: 8];
      end
      mm[key] = word;
   endfunction

   function automatic logic [63:0] model_read(int k, logic [63:0] a);
      if (!in_window(k, a)) return 64'h0;
      return mm.exists(key_of(k, a)) ? mm[key_of(k, a)] : 64'hx;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete transfer; returns what the DUT did, nothing is judged here.
   task automatic xfer(input int k, input logic w, input logic [63:0] a, input logic [63:0] d,
                       input logic [7:0] s, output int lat, output logic got_ack, output logic got_err,
                       output logic [63:0] got_data, output logic [63:0] after_data,
                       output logic after_term, output logic idle_dirty);
      dut_sel = 2'(k); we = w; addr = a; wdata = d; sel = s; cyc = 1'b1; stb = 1'b1;
      lat = -1; got_ack = 1'b0; got_err = 1'b0; got_data = '0; idle_dirty = 1'b0;
      for (int n = 1; n <= 40 && lat < 0; n++) begin
         step();
         if (ack_m || err_m) begin
            lat = n; got_ack = ack_m; got_err = err_m; got_data = rdata_m;
            cyc = 1'b0; stb = 1'b0;
         end else if (rdata_m !== 64'h0) begin
            idle_dirty = 1'b1;
         end
      end
      cyc = 1'b0; stb = 1'b0;
      step();
      after_data = rdata_m;
      after_term = ack_m | err_m;
   endtask

   int          lat;
   logic        g_ack, g_err, a_term, dirty;
   logic [63:0] g_data, a_data, expd;

   task automatic test_reset();
      rst = 1'b1; dut_sel = 2'd0; cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 64'h10;
      wdata = '0; sel = 8'hFF;
      for (int c = 0; c < 3; c++) begin
         step();
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({ack_a[k], err_a[k], rdata_a[k]} !== 66'h0)
               $display("FAIL reset_outputs dut%0d: ack=%b err=%b data=%h, want all 0", k, ack_a[k], err_a[k], rdata_a[k]);
            else n_pass++;
         end
      end
      cyc = 1'b0; stb = 1'b0;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      xfer(0, 1'b1, 64'h10, 64'h0123456789ABCDEF, 8'hFF, lat, g_ack, g_err, g_data, a_data, a_term, dirty);
      model_apply(0, 1'b1, 64'h10, 64'h0123456789ABCDEF, 8'hFF);
      n_checks++;
      if (lat !== 2 || {g_ack, g_err} !== 2'b10)
         $display("FAIL basic_write: lat=%0d ack=%b err=%b, want lat=2 ack=1 err=0", lat, g_ack, g_err);
      else n_pass++;
      xfer(0, 1'b0, 64'h10, 64'h0, 8'hFF, lat, g_ack, g_err, g_data, a_data, a_term, dirty);
      n_checks++;
      if (lat !== 2 || {g_ack, g_err} !== 2'b10)
         $display("FAIL basic_read_term: lat=%0d ack=%b err=%b, want lat=2 ack=1 err=0", lat, g_ack, g_err);
      else n_pass++;
      n_checks++;
      if (g_data !== 64'h0123456789ABCDEF)
         $display("FAIL basic_read_data: got %h want %h", g_data, 64'h0123456789ABCDEF);
      else n_pass++;
      n_checks++;
      if (a_data !== 64'h0 || a_term !== 1'b0 || dirty !== 1'b0)
         $display("FAIL basic_data_idle: after=%h term=%b dirty=%b, want 0/0/0", a_data, a_term, dirty);
      else n_pass++;
   endtask

   task automatic test_byte_lanes();
      xfer(0, 1'b1, 64'h10, 64'hFFFFFFFFFFFFFFFF, 8'h0F, lat, g_ack, g_err, g_data, a_data, a_term, dirty);
      model_apply(0, 1'b1, 64'h10, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
      xfer(0, 1'b0, 64'h10, 64'h0, 8'h00, lat, g_ack, g_err, g_data, a_data, a_term, dirty);
      n_checks++;
      if (g_data !== 64'h01234567FFFFFFFF || g_data !== model_read(0, 64'h10))
         $display("FAIL lanes_low_half: got %h want %h", g_data, 64'h01234567FFFFFFFF);
      else n_pass++;
      xfer(0, 1'b1, 64'h13, 64'h5A5A5A5A5A5A5A5A, 8'h00, lat, g_ack, g_err, g_data, a_data, a_term, dirty);
      n_checks++;
      if (lat !== 2 || {g_ack, g_err} !== 2'b10)
         $display("FAIL lanes_sel0_ack: lat=%0d ack=%b err=%b, want lat=2 ack=1 err=0", lat, g_ack, g_err);
      else n_pass++;
      xfer(0, 1'b0, 64'h17, 64'h0, 8'hFF, lat, g_ack, g_err, g_data, a_data, a_term, dirty);
      n_checks++;
      if (g_data !== 64'h01234567FFFFFFFF)
         $display("FAIL lanes_sel0_keep: got %h want %h", g_data, 64'h01234567FFFFFFFF);
      else n_pass++;
   endtask

   task automatic test_window();
      logic [63:0] probe [3];
      probe[0] = 64'h1000_0000; probe[1] = 64'h1000_0008; probe[2] = 64'h1000_1FF8;
      for (int i = 0; i < 3; i++) begin
         expd = {$urandom, $urandom};
         xfer(1, 1'b1, probe[i], expd, 8'hFF, lat, g_ack, g_err, g_data, a_data, a_term, dirty);
         model_apply(1, 1'b1, probe[i], expd, 8'hFF);
      end
      xfer(1, 1'b0, 64'h1000_2000, 64'h0, 8'hFF, lat, g_ack, g_err, g_data, a_data, a_term, dirty);
      n_checks++;
      if (lat !== 2 || {g_ack, g_err} !== 2'b01 || g_data !== 64'h0)
         $display("FAIL window_read_err: lat=%0d ack=%b err=%b data=%h, want lat=2 ack=0 err=1 data=0", lat, g_ack, g_err, g_data);
      else n_pass++;
      xfer(1, 1'b1, 64'h0, 64'hDEADBEEFCAFEF00D, 8'hFF, lat, g_ack, g_err, g_data, a_data, a_term, dirty);
      n_checks++;
      if (lat !== 2 || {g_ack, g_err} !== 2'b01)
         $display("FAIL window_write_err: lat=%0d ack=%b err=%b, want lat=2 ack=0 err=1", lat, g_ack, g_err);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         xfer(1, 1'b0, probe[i], 64'h0, 8'hFF, lat, g_ack, g_err, g_data, a_data, a_term, dirty);
         n_checks++;
         if ({g_ack, g_err} !== 2'b10 || g_data !== model_read(1, probe[i]))
            $display("FAIL window_intact[%0d]: ack=%b data=%h want ack=1 data=%h", i, g_ack, g_data, model_read(1, probe[i]));
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] a [3];
      int          j;
      a[0] = 64'h0; a[1] = 64'h8; a[2] = 64'h10;
      for (int i = 0; i < 3; i++) begin
         expd = {$urandom, $urandom};
         xfer(2, 1'b1, a[i], expd, 8'hFF, lat, g_ack, g_err, g_data, a_data, a_term, dirty);
         model_apply(2, 1'b1, a[i], expd, 8'hFF);
         n_checks++;
         if (lat !== 1 || g_ack !== 1'b1)
            $display("FAIL b2b_prewrite[%0d]: lat=%0d ack=%b, want lat=1 ack=1", i, lat, g_ack);
         else n_pass++;
      end
      dut_sel = 2'd2; we = 1'b0; sel = 8'hFF; addr = a[0]; cyc = 1'b1; stb = 1'b1;
      j = 0;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) step();
         n_checks++;
         if (ack_m !== 1'(c % 2))
            $display("FAIL b2b_ack_cycle%0d: ack=%b want %b", c, ack_m, 1'(c % 2));
         else n_pass++;
         if (ack_m === 1'b1 && j < 3) begin
            n_checks++;
            if (rdata_m !== model_read(2, a[j]))
               $display("FAIL b2b_data[%0d]: got %h want %h", j, rdata_m, model_read(2, a[j]));
            else n_pass++;
            j++;
            if (j < 3) addr = a[j];
            else begin cyc = 1'b0; stb = 1'b0; end
         end
      end
      cyc = 1'b0; stb = 1'b0;
      step();
   endtask

   task automatic test_abort();
      logic seen;
      expd = {$urandom, $urandom};
      xfer(3, 1'b1, 64'h18, expd, 8'hFF, lat, g_ack, g_err, g_data, a_data, a_term, dirty);
      model_apply(3, 1'b1, 64'h18, expd, 8'hFF);
      dut_sel = 2'd3; we = 1'b1; addr = 64'h18; wdata = 64'hAAAAAAAAAAAAAAAA; sel = 8'hFF;
      cyc = 1'b1; stb = 1'b1;
      step();
      step();
      stb = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (ack_m || err_m) seen = 1'b1;
      end
      cyc = 1'b0;
      n_checks++;
      if (seen !== 1'b0) $display("FAIL abort_no_term: termination seen=%b want 0", seen);
      else n_pass++;
      xfer(3, 1'b0, 64'h18, 64'h0, 8'hFF, lat, g_ack, g_err, g_data, a_data, a_term, dirty);
      n_checks++;
      if (lat !== 4 || g_ack !== 1'b1 || g_data !== model_read(3, 64'h18))
         $display("FAIL abort_prior: lat=%0d ack=%b data=%h want lat=4 ack=1 data=%h", lat, g_ack, g_data, model_read(3, 64'h18));
      else n_pass++;
   endtask

   task automatic test_reset_midop();
      logic seen;
      for (int v = 0; v < 2; v++) begin
         dut_sel = 2'd3; we = 1'(v); addr = 64'h18; wdata = 64'h5555555555555555; sel = 8'hFF;
         cyc = 1'b1; stb = 1'b1;
         step();
         step();
         step();
         rst = 1'b1;
         n_checks++;
         if ({ack_m, err_m, rdata_m} !== 66'h0)
            $display("FAIL rst_mid_outputs[%0d]: ack=%b err=%b data=%h want 0", v, ack_m, err_m, rdata_m);
         else n_pass++;
         step();
         rst = 1'b0; cyc = 1'b0; stb = 1'b0;
         seen = 1'b0;
         for (int c = 0; c < 8; c++) begin
            step();
            if (ack_m || err_m || rdata_m !== 64'h0) seen = 1'b1;
         end
         n_checks++;
         if (seen !== 1'b0) $display("FAIL rst_mid_quiet[%0d]: activity=%b want 0", v, seen);
         else n_pass++;
      end
      xfer(3, 1'b0, 64'h18, 64'h0, 8'hFF, lat, g_ack, g_err, g_data, a_data, a_term, dirty);
      n_checks++;
      if (lat !== 4 || g_ack !== 1'b1 || g_data !== model_read(3, 64'h18))
         $display("FAIL rst_mid_fresh: lat=%0d ack=%b data=%h want lat=4 ack=1 data=%h", lat, g_ack, g_data, model_read(3, 64'h18));
      else n_pass++;
   endtask

   task automatic test_random();
      logic [63:0] a, d;
      logic        w, inw;
      logic [7:0]  s;
      int          idx;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 8; i++) begin
            a = base_of(k) + 64'((i * 131 + k * 7) % 1024) * 64'd8;
            d = {$urandom, $urandom};
            xfer(k, 1'b1, a, d, 8'hFF, lat, g_ack, g_err, g_data, a_data, a_term, dirty);
            model_apply(k, 1'b1, a, d, 8'hFF);
         end
         for (int t = 0; t < 30; t++) begin
            idx = $urandom_range(0, 7);
            if ($urandom_range(0, 5) == 0) a = {$urandom, $urandom} | 64'h0000_0100_0000_0000;
            else a = base_of(k) + 64'((idx * 131 + k * 7) % 1024) * 64'd8 + 64'($urandom_range(0, 7));
            w   = 1'($urandom_range(0, 1));
            s   = 8'($urandom);
            d   = {$urandom, $urandom};
            inw = in_window(k, a);
            expd = w ? 64'h0 : model_read(k, a);
            xfer(k, w, a, d, s, lat, g_ack, g_err, g_data, a_data, a_term, dirty);
            model_apply(k, w, a, d, s);
            n_checks++;
            if (lat !== ws_of(k) + 1 || {g_ack, g_err} !== {inw, ~inw})
               $display("FAIL rand_term dut%0d t%0d: lat=%0d ack=%b err=%b want lat=%0d ack=%b err=%b",
                        k, t, lat, g_ack, g_err, ws_of(k) + 1, inw, ~inw);
            else n_pass++;
            if (!w) begin
               n_checks++;
               if (g_data !== expd)
                  $display("FAIL rand_rdata dut%0d t%0d addr=%h: got %h want %h", k, t, a, g_data, expd);
               else n_pass++;
            end
            n_checks++;
            if (dirty !== 1'b0 || a_data !== 64'h0 || a_term !== 1'b0)
               $display("FAIL rand_idle dut%0d t%0d: dirty=%b after=%h term=%b want 0", k, t, dirty, a_data, a_term);
            else n_pass++;
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      test_reset();
      test_basic();
      test_byte_lanes();
      test_window();
      test_back_to_back();
      test_abort();
      test_reset_midop();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
